// File: rtl/ls148_irq_pkg.sv
// rtl/ls148_irq_pkg.sv - shared types, constants and priority encoder for ls148_irq_encoder
//
// Purpose: holds the encoder FSM state type, the request-line count and the
// priority-encode helper used by the top level.
// Ports: none (package).

package ls148_irq_pkg;

  localparam int N_REQ = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    HOLDOFF = 2'd2
  } state_e;

  // Index of the highest set bit; bit 7 has the highest priority.
  // Returns 0 for an all-zero vector, callers only use it when req != 0.
  function automatic logic [2:0] prio_enc(input logic [N_REQ-1:0] req);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_sync.sv
// rtl/irq_sync.sv - single-bit multi-flop synchroniser with reset value 1
//
// Purpose: brings one asynchronous, active-low request line into the clk
// domain. All stages reset to 1 (the idle level of an active-low line).
// Ports:
//   clk   in  clock
//   _rst  in  synchronous active-low reset
//   d     in  asynchronous input
//   q     out synchronised output (last stage)

module irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic _rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stage_q;
  logic [STAGES-1:0] stage_d;

  always_comb begin
    stage_d = {stage_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (!_rst) begin
      stage_q <= '1;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/ls148_irq_encoder.sv
// rtl/ls148_irq_encoder.sv - 74LS148-style prioritised interrupt encoder with acknowledge handshake
//
// Purpose: synchronises eight active-low request lines, records pending
// requests (falling-edge captured or level), presents the highest pending
// index until acknowledged, then inserts one holdoff cycle.
// Ports:
//   clk   in   1  sole clock, rising edge
//   _rst  in   1  synchronous active-low reset
//   _I    in   8  active-low asynchronous requests, bit 7 highest priority
//   _EI   in   1  active-low enable
//   _ACK  in   1  active-low acknowledge of the presented code
//   _A    out  3  active-low encoded index (3'b111 when nothing presented)
//   _GS   out  1  low while a code is presented
//   _EO   out  1  low when enabled, idle and nothing pending

module ls148_irq_encoder
  import ls148_irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 1
) (
  input  logic             clk,
  input  logic             _rst,
  input  logic [N_REQ-1:0] _I,
  input  logic             _EI,
  input  logic             _ACK,
  output logic [2:0]       _A,
  output logic             _GS,
  output logic             _EO
);

  localparam logic [1:0] SETTLE_MAX = 2'(SYNC_STAGES);

  logic [N_REQ-1:0] sync_n;

  for (genvar n = 0; n < N_REQ; n++) begin : g_sync
    irq_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      ._rst (_rst),
      .d    (_I[n]),
      .q    (sync_n[n])
    );
  end

  state_e           state_q, state_d;
  logic [2:0]       code_q, code_d;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic [N_REQ-1:0] prev_hi_q, prev_hi_d;
  logic [1:0]       settle_q, settle_d;
  logic [2:0]       a_q, a_d;
  logic             gs_q, gs_d;
  logic             eo_q, eo_d;

  logic             settle_done;
  logic [N_REQ-1:0] fall;
  logic [N_REQ-1:0] ack_clr;

  // After reset the synchroniser still holds its reset 1s; its output only
  // reflects real post-reset samples once SYNC_STAGES edges have passed.
  // prev_hi tracks the last real sample and starts at 0, so a line held low
  // through reset release never looks like a falling edge.
  assign settle_done = (settle_q == SETTLE_MAX);
  assign fall        = prev_hi_q & ~sync_n;

  always_comb begin
    settle_d  = settle_done ? settle_q : settle_q + 2'd1;
    prev_hi_d = settle_done ? sync_n : prev_hi_q;
    state_d   = state_q;
    code_d    = code_q;
    ack_clr   = '0;

    unique case (state_q)
      IDLE: begin
        if (!_EI && (pending_q != '0)) begin
          code_d  = prio_enc(pending_q);
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        // Disable wins over a simultaneous acknowledge; pending is kept.
        if (_EI) begin
          state_d = IDLE;
        end else if (!_ACK) begin
          ack_clr[code_q] = 1'b1;
          state_d         = HOLDOFF;
        end
      end
      HOLDOFF: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A fresh edge in the same cycle as the acknowledge clear keeps the bit set.
    if (EDGE_MODE != 0) begin
      pending_d = (pending_q & ~ack_clr) | fall;
    end else begin
      pending_d = ~sync_n;
    end

    a_d  = (state_d == PRESENT) ? ~code_d : 3'b111;
    gs_d = (state_d != PRESENT);
    eo_d = !(!_EI && (state_d == IDLE) && (pending_d == '0));
  end

  always_ff @(posedge clk) begin
    if (!_rst) begin
      state_q   <= IDLE;
      code_q    <= 3'd0;
      pending_q <= '0;
      prev_hi_q <= '0;
      settle_q  <= 2'd0;
      a_q       <= 3'b111;
      gs_q      <= 1'b1;
      eo_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      pending_q <= pending_d;
      prev_hi_q <= prev_hi_d;
      settle_q  <= settle_d;
      a_q       <= a_d;
      gs_q      <= gs_d;
      eo_q      <= eo_d;
    end
  end

  assign _A  = a_q;
  assign _GS = gs_q;
  assign _EO = eo_q;

endmodule

// File: tb/tb_ls148_irq_encoder.sv
// tb/tb_ls148_irq_encoder.sv - self-checking bench for ls148_irq_encoder (edge and level instances)

module tb_ls148_irq_encoder;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       r_rst = 1'b0;
  logic [7:0] r_i = 8'hFF;
  logic       r_ei = 1'b0;
  logic       r_ack = 1'b1;

  logic [2:0] a_e, a_l;
  logic       gs_e, gs_l, eo_e, eo_l;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ls148_irq_encoder #(.SYNC_STAGES(SYNC), .EDGE_MODE(1)) dut_e (
    .clk(clk), ._rst(r_rst), ._I(r_i), ._EI(r_ei), ._ACK(r_ack),
    ._A(a_e), ._GS(gs_e), ._EO(eo_e)
  );

  ls148_irq_encoder #(.SYNC_STAGES(SYNC), .EDGE_MODE(0)) dut_l (
    .clk(clk), ._rst(r_rst), ._I(r_i), ._EI(r_ei), ._ACK(r_ack),
    ._A(a_l), ._GS(gs_l), ._EO(eo_l)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Index 0 models the edge-mode instance, index 1 the level-mode instance.
  logic [7:0] hist[$];
  int         edges;
  bit         model_on = 1'b0;
  logic [7:0] pend[2];
  int         ph[2];
  int         code[2];
  bit         have_last[2];
  logic [7:0] last[2];
  logic [2:0] ea[2];
  logic       egs[2];
  logic       eeo[2];

  function automatic int top_bit(input logic [7:0] v);
    for (int n = 7; n >= 0; n--) begin
      if (v[n]) return n;
    end
    return 0;
  endfunction

  always @(posedge clk) begin : mdl
    logic [7:0] syncv, fall, clr, npend;
    int         nph, ncode;
    bit         genuine;
    if (!r_rst) begin
      hist.delete();
      for (int k = 0; k < SYNC; k++) hist.push_back(8'hFF);
      edges = 0;
      for (int m = 0; m < 2; m++) begin
        pend[m] = 8'h00; ph[m] = 0; code[m] = 0;
        have_last[m] = 1'b0; last[m] = 8'h00;
        ea[m] = 3'b111; egs[m] = 1'b1; eeo[m] = 1'b1;
      end
      model_on = 1'b1;
    end else if (model_on) begin
      syncv   = hist[0];
      genuine = (edges >= SYNC);
      for (int m = 0; m < 2; m++) begin
        fall  = have_last[m] ? (last[m] & ~syncv) : 8'h00;
        clr   = 8'h00;
        nph   = ph[m];
        ncode = code[m];
        if (ph[m] == 0) begin
          if (!r_ei && pend[m] != 8'h00) begin
            ncode = top_bit(pend[m]);
            nph   = 1;
          end
        end else if (ph[m] == 1) begin
          if (r_ei) nph = 0;
          else if (!r_ack) begin
            clr = 8'(1 << code[m]);
            nph = 2;
          end
        end else begin
          nph = 0;
        end
        npend = (m == 0) ? ((pend[m] & ~clr) | fall) : ~syncv;
        if (genuine) begin
          have_last[m] = 1'b1;
          last[m]      = syncv;
        end
        pend[m] = npend;
        ph[m]   = nph;
        code[m] = ncode;
        ea[m]   = (nph == 1) ? ~3'(ncode) : 3'b111;
        egs[m]  = (nph != 1);
        eeo[m]  = !(!r_ei && nph == 0 && npend == 8'h00);
      end
      hist.push_back(r_i);
      void'(hist.pop_front());
      if (edges < 1000) edges++;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("edge_A",  32'(a_e),  32'(ea[0]));
      chk("edge_GS", 32'(gs_e), 32'(egs[0]));
      chk("edge_EO", 32'(eo_e), 32'(eeo[0]));
      chk("lvl_A",   32'(a_l),  32'(ea[1]));
      chk("lvl_GS",  32'(gs_l), 32'(egs[1]));
      chk("lvl_EO",  32'(eo_l), 32'(eeo[1]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ack_pulse();
    r_ack = 1'b0;
    step(1);
    r_ack = 1'b1;
  endtask

  initial begin
    step(2);
    chk("rst_A",  32'(a_e),  32'h7);
    chk("rst_GS", 32'(gs_e), 32'h1);
    chk("rst_EO", 32'(eo_e), 32'h1);
    r_rst = 1'b1;
    step(4);

    // single request, latency and acknowledge
    r_i[5] = 1'b0;
    step(3);
    chk("r32_GS_early", 32'(gs_e), 32'h1);
    step(1);
    chk("r32_GS", 32'(gs_e), 32'h0);
    chk("r32_A",  32'(a_e),  32'h2);
    ack_pulse();
    chk("r32_hold_GS", 32'(gs_e), 32'h1);
    chk("r32_hold_A",  32'(a_e),  32'h7);
    step(1);
    chk("r32_EO", 32'(eo_e), 32'h0);
    r_i = 8'hFF;
    step(3);

    // two simultaneous requests
    r_i[2] = 1'b0; r_i[6] = 1'b0;
    step(4);
    chk("r33_A6", 32'(a_e), 32'h1);
    ack_pulse();
    chk("r33_hold_GS", 32'(gs_e), 32'h1);
    step(2);
    chk("r33_A2",  32'(a_e),  32'h5);
    chk("r33_GS2", 32'(gs_e), 32'h0);
    ack_pulse();
    step(1);
    chk("r33_EO", 32'(eo_e), 32'h0);
    r_i = 8'hFF;
    step(3);

    // no preemption by a higher-priority arrival
    r_i[1] = 1'b0;
    step(4);
    chk("r34_A1", 32'(a_e), 32'h6);
    r_i[7] = 1'b0;
    step(6);
    chk("r34_A1_held", 32'(a_e), 32'h6);
    ack_pulse();
    step(2);
    chk("r34_A7", 32'(a_e), 32'h0);
    ack_pulse();
    step(1);
    chk("r34_EO", 32'(eo_e), 32'h0);
    r_i = 8'hFF;
    step(3);

    // disable while presenting, then re-present without ack
    r_i[3] = 1'b0;
    step(4);
    chk("r35_A3", 32'(a_e), 32'h4);
    r_ei = 1'b1;
    step(1);
    chk("r35_dis_GS", 32'(gs_e), 32'h1);
    chk("r35_dis_EO", 32'(eo_e), 32'h1);
    chk("r35_dis_A",  32'(a_e),  32'h7);
    r_ei = 1'b0;
    step(1);
    chk("r35_re_A",  32'(a_e),  32'h4);
    chk("r35_re_GS", 32'(gs_e), 32'h0);
    ack_pulse();
    step(1);
    chk("r35_EO", 32'(eo_e), 32'h0);
    r_i = 8'hFF;
    step(3);

    // reset mid-presentation with the line held low
    r_i[4] = 1'b0;
    step(4);
    chk("r36_A4", 32'(a_e), 32'h3);
    r_rst = 1'b0;
    step(1);
    chk("r36_rst_A",  32'(a_e),  32'h7);
    chk("r36_rst_GS", 32'(gs_e), 32'h1);
    chk("r36_rst_EO", 32'(eo_e), 32'h1);
    r_rst = 1'b1;
    step(10);
    chk("r36_noedge_GS", 32'(gs_e), 32'h1);
    chk("r36_noedge_EO", 32'(eo_e), 32'h0);
    r_i = 8'hFF;
    step(4);
    chk("r36_rise_GS", 32'(gs_e), 32'h1);

    // level mode re-presentation after holdoff
    r_rst = 1'b0;
    step(1);
    r_rst = 1'b1;
    r_i[0] = 1'b0;
    step(6);
    chk("r37_GS", 32'(gs_l), 32'h0);
    chk("r37_A",  32'(a_l),  32'h7);
    ack_pulse();
    chk("r37_hold_GS", 32'(gs_l), 32'h1);
    step(2);
    chk("r37_re_GS", 32'(gs_l), 32'h0);
    chk("r37_re_A",  32'(a_l),  32'h7);
    r_i = 8'hFF;
    step(4);
    ack_pulse();
    step(3);

    // randomized traffic checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 10) r_i[$urandom_range(0, 7)] ^= 1'b1;
      r_ei  = ($urandom_range(0, 99) < 7);
      r_ack = !($urandom_range(0, 99) < 30);
      r_rst = !($urandom_range(0, 999) < 6);
      step(1);
    end
    r_rst = 1'b1; r_ack = 1'b1; r_ei = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
